// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker
// Decodes 3-byte PS/2 mouse packets into an absolute, screen-clamped cursor
// position plus left/right button state.
//
// Byte input handshake: rx_valid is a one-cycle strobe that qualifies rx_data;
// there is no back-pressure, so every strobed byte is either consumed, held in
// the one-entry latch (while the FSM sits in APPLY), or discarded as out of sync.
module mouse_position_tracker #(
    parameter int MAX_X          = 800,
    parameter int MAX_Y          = 600,
    parameter int INIT_X         = 400,
    parameter int INIT_Y         = 300,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] mouse_x_position,
    output logic [11:0] mouse_y_position,
    output logic        mouse_left,
    output logic        mouse_right,
    output logic        packet_valid,
    output logic        sync_error
);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [13:0] X_HI = 14'(MAX_X - 1);
    localparam logic signed [13:0] Y_HI = 14'(MAX_Y - 1);

    state_t state, state_next;

    logic [TW-1:0]      timer;
    logic [7:0]         b0_r, b1_r, b2_r;
    logic               hold_valid;
    logic [7:0]         hold_data;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               timeout;
    logic               waiting_mid;
    logic signed [8:0]  dx9, dy9;
    logic signed [13:0] sum_x, sum_y;
    logic               commit;
    logic               left_r, right_r;

    // Byte source selection: a byte held during APPLY is consumed before live input.
    always_comb begin
        in_valid    = 1'b0;
        in_data     = rx_data;
        waiting_mid = (state == WAIT_B1) || (state == WAIT_B2);
        if (state != APPLY) begin
            in_valid = hold_valid || rx_valid;
            in_data  = hold_valid ? hold_data : rx_data;
        end
        timeout = waiting_mid && !in_valid && (timer == TW'(TIMEOUT_CYCLES));
        dx9     = b0_r[6] ? 9'sd0 : $signed({b0_r[4], b1_r});
        dy9     = b0_r[7] ? 9'sd0 : $signed({b0_r[5], b2_r});
    end

    // Next-state logic; an arriving byte always takes precedence over a timeout.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_B0: if (in_valid && in_data[3]) state_next = WAIT_B1;
            WAIT_B1: begin
                if (in_valid)     state_next = WAIT_B2;
                else if (timeout) state_next = WAIT_B0;
            end
            WAIT_B2: begin
                if (in_valid)     state_next = APPLY;
                else if (timeout) state_next = WAIT_B0;
            end
            APPLY:   state_next = WAIT_B0;
            default: state_next = WAIT_B0;
        endcase
    end

    // State register, byte capture, hold latch and inter-byte timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_B0;
            timer      <= '0;
            b0_r       <= '0;
            b1_r       <= '0;
            b2_r       <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            sync_error <= 1'b0;
        end else begin
            state      <= state_next;
            sync_error <= ((state == WAIT_B0) && in_valid && !in_data[3]) || timeout;

            if (state == APPLY) begin
                if (rx_valid) begin
                    hold_valid <= 1'b1;
                    hold_data  <= rx_data;
                end
            end else if (hold_valid) begin
                // Held byte is consumed now; a simultaneous live byte takes its place.
                if (rx_valid) hold_data  <= rx_data;
                else          hold_valid <= 1'b0;
            end

            if (in_valid) begin
                case (state)
                    WAIT_B0: if (in_data[3]) b0_r <= in_data;
                    WAIT_B1: b1_r <= in_data;
                    WAIT_B2: b2_r <= in_data;
                    default: ;
                endcase
            end

            if (in_valid || timeout || !waiting_mid) timer <= '0;
            else                                     timer <= timer + 1'b1;
        end
    end

    // Two-step update: APPLY forms the unclamped sums, the following edge clamps and publishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_x            <= '0;
            sum_y            <= '0;
            commit           <= 1'b0;
            left_r           <= 1'b0;
            right_r          <= 1'b0;
            mouse_x_position <= 12'(INIT_X);
            mouse_y_position <= 12'(INIT_Y);
            mouse_left       <= 1'b0;
            mouse_right      <= 1'b0;
            packet_valid     <= 1'b0;
        end else begin
            commit       <= (state == APPLY);
            packet_valid <= commit;
            if (state == APPLY) begin
                sum_x   <= $signed({2'b00, mouse_x_position}) + {{5{dx9[8]}}, dx9};
                sum_y   <= $signed({2'b00, mouse_y_position}) - {{5{dy9[8]}}, dy9};
                left_r  <= b0_r[0];
                right_r <= b0_r[1];
            end
            if (commit) begin
                if (sum_x < 14'sd0)     mouse_x_position <= 12'd0;
                else if (sum_x > X_HI)  mouse_x_position <= X_HI[11:0];
                else                    mouse_x_position <= sum_x[11:0];
                if (sum_y < 14'sd0)     mouse_y_position <= 12'd0;
                else if (sum_y > Y_HI)  mouse_y_position <= Y_HI[11:0];
                else                    mouse_y_position <= sum_y[11:0];
                mouse_left  <= left_r;
                mouse_right <= right_r;
            end
        end
    end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb_mouse_position_tracker
// Directed bench: a small reference model computes the expected cursor state
// for each packet and queues it; a negedge monitor pops and compares whenever
// packet_valid pulses.
module tb_mouse_position_tracker;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] mouse_x_position, mouse_y_position;
    logic        mouse_left, mouse_right, packet_valid, sync_error;

    int total = 0;
    int bad   = 0;
    int pv_cnt = 0;
    int sync_cnt = 0;
    int pushed = 0;
    int mx, my;
    logic ml, mr;
    logic [25:0] exp_q[$];

    mouse_position_tracker #(
        .MAX_X(800), .MAX_Y(600), .INIT_X(400), .INIT_Y(300), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .mouse_x_position(mouse_x_position),
        .mouse_y_position(mouse_y_position),
        .mouse_left(mouse_left),
        .mouse_right(mouse_right),
        .packet_valid(packet_valid),
        .sync_error(sync_error)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: applies one packet to the model cursor and queues the result.
    task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (b0[6]) dx = 0;
        if (b0[7]) dy = 0;
        mx = mx + dx;
        my = my - dy;
        if (mx < 0) mx = 0;
        if (mx > 799) mx = 799;
        if (my < 0) my = 0;
        if (my > 599) my = 599;
        ml = b0[0];
        mr = b0[1];
        exp_q.push_back({12'(mx), 12'(my), ml, mr});
        pushed++;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [25:0] e;
        if (sync_error) sync_cnt++;
        if (packet_valid) begin
            pv_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_packet", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pkt_x", 32'(mouse_x_position), 32'(e[25:14]));
                check("pkt_y", 32'(mouse_y_position), 32'(e[13:2]));
                check("pkt_left", 32'(mouse_left), 32'(e[1]));
                check("pkt_right", 32'(mouse_right), 32'(e[0]));
            end
        end
    end

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        push_pkt(b0, b1, b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        @(posedge clk); #1;
        check("latency_pv_early", 32'(packet_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_pv_on", 32'(packet_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        mx = 400;
        my = 300;
        ml = 1'b0;
        mr = 1'b0;
    endtask

    initial begin
        int s0;
        do_reset();
        check("rst_x", 32'(mouse_x_position), 32'd400);
        check("rst_y", 32'(mouse_y_position), 32'd300);
        check("rst_left", 32'(mouse_left), 32'd0);
        check("rst_right", 32'(mouse_right), 32'd0);
        check("rst_pv", 32'(packet_valid), 32'd0);
        check("rst_sync", 32'(sync_error), 32'd0);

        // 1: simple +16 in x
        send_packet(8'h08, 8'h10, 8'h00);
        check("t1_x", 32'(mouse_x_position), 32'd416);
        check("t1_no_sync", 32'(sync_cnt), 32'd0);

        // 2: left button with dy=+32 (cursor moves up)
        do_reset();
        send_packet(8'h09, 8'h00, 8'h20);
        check("t2_y", 32'(mouse_y_position), 32'd268);
        check("t2_x", 32'(mouse_x_position), 32'd400);

        // 3: dx=-128 repeatedly until clamped at 0
        do_reset();
        for (int i = 0; i < 5; i++) send_packet(8'h18, 8'h80, 8'h00);
        check("t3_x_clamp0", 32'(mouse_x_position), 32'd0);

        // 4: out-of-sync byte then a good packet
        do_reset();
        s0 = sync_cnt;
        send_byte(8'h07);
        check("t4_sync_pulse", 32'(sync_error), 32'd1);
        send_packet(8'h08, 8'h05, 8'h00);
        check("t4_x", 32'(mouse_x_position), 32'd405);
        check("t4_sync_count", 32'(sync_cnt), 32'(s0 + 1));

        // 5: inter-byte timeout drops the partial packet
        do_reset();
        s0 = sync_cnt;
        send_byte(8'h08);
        repeat (TO + 10) @(posedge clk);
        #1;
        check("t5_timeout_sync", 32'(sync_cnt), 32'(s0 + 1));
        check("t5_x_same", 32'(mouse_x_position), 32'd400);
        check("t5_y_same", 32'(mouse_y_position), 32'd300);
        send_packet(8'h08, 8'h01, 8'h00);
        check("t5_x", 32'(mouse_x_position), 32'd401);

        // 6: x overflow, then reset in the middle of a packet
        do_reset();
        send_packet(8'h48, 8'h7F, 8'h00);
        check("t6_ovf_x", 32'(mouse_x_position), 32'd400);
        send_byte(8'h08);
        send_byte(8'h10);
        do_reset();
        check("t6_rst_x", 32'(mouse_x_position), 32'd400);
        check("t6_rst_y", 32'(mouse_y_position), 32'd300);
        send_packet(8'h08, 8'h02, 8'h00);
        check("t6_x", 32'(mouse_x_position), 32'd402);

        // Back-to-back packets: first byte of packet 2 arrives during APPLY
        push_pkt(8'h08, 8'h01, 8'h00);
        push_pkt(8'h0A, 8'h01, 8'h00);
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h0A); send_byte(8'h01); send_byte(8'h00);
        repeat (6) @(posedge clk);
        #1;
        check("b2b_x", 32'(mouse_x_position), 32'd404);
        check("b2b_right", 32'(mouse_right), 32'd1);

        // Upper clamps: dy=-256 moves down, dx=+255 moves right
        send_packet(8'h28, 8'h00, 8'h00);
        send_packet(8'h28, 8'h00, 8'h00);
        check("y_clamp_hi", 32'(mouse_y_position), 32'd599);
        send_packet(8'h08, 8'hFF, 8'h00);
        send_packet(8'h08, 8'hFF, 8'h00);
        check("x_clamp_hi", 32'(mouse_x_position), 32'd799);

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("pv_count", 32'(pv_cnt), 32'(pushed));
        check("sync_total", 32'(sync_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
